// File: rtl/gemm_pkg.sv
// Shared sizes, tag payload and bank state type for the GEMM C-tile output path.
package gemm_pkg;

   localparam int unsigned M          = 4;
   localparam int unsigned N          = 4;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned IDX_WIDTH  = 16;
   localparam int unsigned ELEMS      = M * N;
   localparam int unsigned TILE_W     = ELEMS * DATA_WIDTH;
   localparam int unsigned ROW_W      = $clog2(M);
   localparam int unsigned COL_W      = $clog2(N);
   localparam int unsigned EIDX_W     = $clog2(ELEMS);
   localparam int unsigned CNT_W      = 16;

   typedef struct packed {
      logic [IDX_WIDTH-1:0] m_idx;
      logic [IDX_WIDTH-1:0] n_idx;
   } tile_tag_t;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_t;

endpackage

// File: rtl/c_tile_bank.sv
// One ping-pong bank: full C tile plus its coordinate tag, loaded in parallel,
// read one element at a time by row-major index.
module c_tile_bank
   import gemm_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [TILE_W-1:0]     wr_data,
   input  tile_tag_t             wr_tag,
   input  logic [EIDX_W-1:0]     rd_idx,
   output logic [DATA_WIDTH-1:0] rd_elem,
   output tile_tag_t             rd_tag
);

   logic [ELEMS-1:0][DATA_WIDTH-1:0] data_q, data_d;
   tile_tag_t                        tag_q, tag_d;

   always_comb begin
      data_d = data_q;
      tag_d  = tag_q;
      if (we) begin
         data_d = wr_data;
         tag_d  = wr_tag;
      end
   end

   // Storage only; validity is tracked by the owner, so no reset is needed here.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   assign rd_elem = data_q[rd_idx];
   assign rd_tag  = tag_q;

endmodule

// File: rtl/c_tile_drain.sv
// Drain end of the 4x4 GEMM output path: two-bank ping-pong buffer that accepts
// whole C tiles and streams them row-major, one element per handshake.
module c_tile_drain
   import gemm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  tile_valid,
   output logic                  tile_ready,
   input  logic [TILE_W-1:0]     tile_data,
   input  logic [IDX_WIDTH-1:0]  tile_m_idx,
   input  logic [IDX_WIDTH-1:0]  tile_n_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ROW_W-1:0]      out_row,
   output logic [COL_W-1:0]      out_col,
   output logic [IDX_WIDTH-1:0]  out_tile_m,
   output logic [IDX_WIDTH-1:0]  out_tile_n,
   output logic                  out_last,
   output logic                  busy,
   output logic [CNT_W-1:0]      tiles_drained
);

   bank_state_t          bank_q [2];
   bank_state_t          bank_d [2];
   logic                 wr_sel_q, wr_sel_d;
   logic                 rd_sel_q, rd_sel_d;
   logic [EIDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]     drained_q, drained_d;

   logic                 load_c;
   logic                 hs_c;
   logic                 last_c;
   logic [DATA_WIDTH-1:0] elem_c [2];
   tile_tag_t            tag_c [2];
   tile_tag_t            wr_tag_c;

   assign wr_tag_c = '{m_idx: tile_m_idx, n_idx: tile_n_idx};

   for (genvar i = 0; i < 2; i++) begin : g_bank
      c_tile_bank u_bank (
         .clk     (clk),
         .we      (load_c && (wr_sel_q == 1'(i))),
         .wr_data (tile_data),
         .wr_tag  (wr_tag_c),
         .rd_idx  (idx_q),
         .rd_elem (elem_c[i]),
         .rd_tag  (tag_c[i])
      );
   end

   // Handshake qualifiers come from registered state only; flush blocks a load.
   assign tile_ready = (bank_q[wr_sel_q] == BANK_EMPTY);
   assign out_valid  = (bank_q[rd_sel_q] == BANK_FULL);
   assign load_c     = tile_valid && tile_ready && !flush;
   assign hs_c       = out_valid && out_ready;
   assign last_c     = out_valid && (idx_q == EIDX_W'(ELEMS - 1));

   always_comb begin
      bank_d    = bank_q;
      wr_sel_d  = wr_sel_q;
      rd_sel_d  = rd_sel_q;
      idx_d     = idx_q;
      drained_d = drained_q;
      if (flush) begin
         bank_d[0] = BANK_EMPTY;
         bank_d[1] = BANK_EMPTY;
         wr_sel_d  = 1'b0;
         rd_sel_d  = 1'b0;
         idx_d     = '0;
      end else begin
         // Load and free always target different banks, so both may apply.
         if (load_c) begin
            bank_d[wr_sel_q] = BANK_FULL;
            wr_sel_d         = ~wr_sel_q;
         end
         if (hs_c) begin
            if (last_c) begin
               bank_d[rd_sel_q] = BANK_EMPTY;
               rd_sel_d         = ~rd_sel_q;
               idx_d            = '0;
               drained_d        = drained_q + CNT_W'(1);
            end else begin
               idx_d = idx_q + EIDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q[0] <= BANK_EMPTY;
         bank_q[1] <= BANK_EMPTY;
         wr_sel_q  <= 1'b0;
         rd_sel_q  <= 1'b0;
         idx_q     <= '0;
         drained_q <= '0;
      end else begin
         bank_q    <= bank_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         idx_q     <= idx_d;
         drained_q <= drained_d;
      end
   end

   // Payload is forced to zero while idle so stale bank contents never show.
   assign out_data      = out_valid ? elem_c[rd_sel_q] : '0;
   assign out_tile_m    = out_valid ? tag_c[rd_sel_q].m_idx : '0;
   assign out_tile_n    = out_valid ? tag_c[rd_sel_q].n_idx : '0;
   assign out_row       = ROW_W'(idx_q / EIDX_W'(N));
   assign out_col       = COL_W'(idx_q % EIDX_W'(N));
   assign out_last      = last_c;
   assign busy          = (bank_q[0] == BANK_FULL) || (bank_q[1] == BANK_FULL);
   assign tiles_drained = drained_q;

endmodule

// File: tb/tb_c_tile_drain.sv
// Scoreboard bench for c_tile_drain: expected beats queued at tile acceptance,
// compared as the drain port hands them off.
module tb_c_tile_drain;
   import gemm_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush;
   logic                  tile_valid;
   logic                  tile_ready;
   logic [TILE_W-1:0]     tile_data;
   logic [IDX_WIDTH-1:0]  tile_m_idx;
   logic [IDX_WIDTH-1:0]  tile_n_idx;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ROW_W-1:0]      out_row;
   logic [COL_W-1:0]      out_col;
   logic [IDX_WIDTH-1:0]  out_tile_m;
   logic [IDX_WIDTH-1:0]  out_tile_n;
   logic                  out_last;
   logic                  busy;
   logic [CNT_W-1:0]      tiles_drained;

   c_tile_drain dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .tile_valid    (tile_valid),
      .tile_ready    (tile_ready),
      .tile_data     (tile_data),
      .tile_m_idx    (tile_m_idx),
      .tile_n_idx    (tile_n_idx),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_row       (out_row),
      .out_col       (out_col),
      .out_tile_m    (out_tile_m),
      .out_tile_n    (out_tile_n),
      .out_last      (out_last),
      .busy          (busy),
      .tiles_drained (tiles_drained)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_WIDTH-1:0] d;
      logic [ROW_W-1:0]      r;
      logic [COL_W-1:0]      c;
      logic [IDX_WIDTH-1:0]  tm;
      logic [IDX_WIDTH-1:0]  tn;
      logic                  last;
   } beat_t;

   beat_t sb [$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    hs_total = 0;
   int    hs_cyc [int];
   int    last_q [$];
   int    acc_cyc = 0;

   logic                  stall_q = 1'b0;
   logic [DATA_WIDTH-1:0] held_d;
   logic [ROW_W-1:0]      held_r;
   logic [COL_W-1:0]      held_c;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare each handshake against the scoreboard and check stall stability.
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q && out_valid) begin
            check_eq("hold_data", 32'(out_data), 32'(held_d));
            check_eq("hold_row",  32'(out_row),  32'(held_r));
            check_eq("hold_col",  32'(out_col),  32'(held_c));
         end
         if (!out_valid) check_eq("idle_last", 32'(out_last), 32'd0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("beat_data",  32'(out_data),   32'(e.d));
               check_eq("beat_row",   32'(out_row),    32'(e.r));
               check_eq("beat_col",   32'(out_col),    32'(e.c));
               check_eq("beat_tag_m", 32'(out_tile_m), 32'(e.tm));
               check_eq("beat_tag_n", 32'(out_tile_n), 32'(e.tn));
               check_eq("beat_last",  32'(out_last),   32'(e.last));
            end
            hs_cyc[hs_total] = cyc;
            hs_total++;
            if (out_last) last_q.push_back(cyc);
         end
         stall_q = out_valid && !out_ready && !flush;
         held_d  = out_data;
         held_r  = out_row;
         held_c  = out_col;
      end
   end

   function automatic logic [TILE_W-1:0] make_tile(input int base);
      logic [TILE_W-1:0] t;
      for (int e = 0; e < int'(ELEMS); e++) t[e*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + e);
      return t;
   endfunction

   task automatic push_tile(input int base, input int m, input int n);
      beat_t b;
      for (int e = 0; e < int'(ELEMS); e++) begin
         b.d    = DATA_WIDTH'(base + e);
         b.r    = ROW_W'(e / int'(N));
         b.c    = COL_W'(e % int'(N));
         b.tm   = IDX_WIDTH'(m);
         b.tn   = IDX_WIDTH'(n);
         b.last = (e == int'(ELEMS) - 1);
         sb.push_back(b);
      end
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic load_tile(input int base, input int m, input int n);
      logic ok;
      ok = 1'b0;
      tile_data  = make_tile(base);
      tile_m_idx = IDX_WIDTH'(m);
      tile_n_idx = IDX_WIDTH'(n);
      tile_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tile_ready) begin
            push_tile(base, m, n);
            acc_cyc = cyc;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("load_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      tile_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 400; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_beats(input int n);
      int base;
      base = hs_total;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (hs_total >= base + n) break;
      end
      if (hs_total < base + n) check_eq("beat_timeout", 32'(hs_total - base), 32'(n));
   endtask

   initial begin
      int base;
      int n0;
      bit pat [3];
      pat = '{1'b1, 1'b0, 1'b0};
      rst = 1'b1; flush = 1'b0; tile_valid = 1'b0; out_ready = 1'b0;
      tile_data = '0; tile_m_idx = '0; tile_n_idx = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_tile_ready", 32'(tile_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_drained", 32'(tiles_drained), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single tile with data e+1, tags (2,3)
      out_ready = 1'b1;
      load_tile(1, 2, 3);
      check_eq("single_busy", 32'(busy), 32'd1);
      wait_drain();
      check_eq("single_drained", 32'(tiles_drained), 32'd1);
      check_eq("single_busy_after", 32'(busy), 32'd0);

      // Back-to-back tiles, no bubble between them
      base = hs_total;
      load_tile(16'h10, 5, 6);
      load_tile(16'h20, 7, 8);
      wait_drain();
      check_eq("b2b_beats", 32'(hs_total - base), 32'd32);
      check_eq("b2b_span", 32'(hs_cyc[base + 31] - hs_cyc[base]), 32'd31);
      check_eq("b2b_drained", 32'(tiles_drained), 32'd3);

      // Backpressure pattern 1,0,0 repeating
      load_tile(16'h100, 9, 1);
      for (int k = 0; k < 300; k++) begin
         if (sb.size() == 0) break;
         out_ready = pat[k % 3];
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain();
      check_eq("bp_drained", 32'(tiles_drained), 32'd4);

      // Both banks full: third tile waits for first tile's last handshake
      out_ready = 1'b0;
      load_tile(16'h30, 1, 1);
      load_tile(16'h40, 1, 2);
      check_eq("full_busy", 32'(busy), 32'd1);
      n0 = last_q.size();
      fork
         load_tile(16'h50, 1, 3);
         begin
            repeat (4) begin
               @(negedge clk);
               check_eq("full_ready", 32'(tile_ready), 32'd0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      if (last_q.size() > n0) check_eq("third_accept_cyc", 32'(acc_cyc), 32'(last_q[n0] + 1));
      else check_eq("third_no_last", 32'(last_q.size()), 32'(n0 + 1));
      wait_drain();
      check_eq("full_drained", 32'(tiles_drained), 32'd7);

      // Flush mid-tile with a competing tile_valid
      load_tile(16'h60, 4, 4);
      wait_beats(4);
      @(posedge clk); #1;
      flush = 1'b1; out_ready = 1'b0;
      tile_data = make_tile(16'h70); tile_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; tile_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_out_valid", 32'(out_valid), 32'd0);
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_row", 32'(out_row), 32'd0);
      check_eq("flush_col", 32'(out_col), 32'd0);
      check_eq("flush_drained", 32'(tiles_drained), 32'd7);
      check_eq("flush_tile_ready", 32'(tile_ready), 32'd1);
      sb.delete();
      @(posedge clk); #1;
      out_ready = 1'b1;
      load_tile(16'h80, 2, 2);
      wait_drain();
      check_eq("post_flush_drained", 32'(tiles_drained), 32'd8);

      // Asynchronous reset mid-stream
      load_tile(16'h90, 3, 3);
      wait_beats(3);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_tile_ready", 32'(tile_ready), 32'd1);
      check_eq("midrst_drained", 32'(tiles_drained), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
